des_decrypt_core: RTL and testbench

DES_DECRYPT_CORE -- requirements
Module: des_decrypt_core

---
 rtl/des_pkg.sv | 121 ++++++++++++
 rtl/des_decrypt_core_if.sv | 37 +++
 rtl/des_f_function.sv | 62 ++++++
 rtl/des_decrypt_core.sv | 129 ++++++++++++
 tb/tb_des_decrypt_core.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// des_pkg: DES permutation tables, key shift schedules, FSM state enum and widths.
// Permutation helpers take/return vectors with DES bit 1 in the MSB.
package des_pkg;

    localparam int BLOCK_W    = 64;
    localparam int HALF_W     = 32;
    localparam int KEY_HALF_W = 28;
    localparam int SUBKEY_W   = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
        8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1
    };

    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
    };

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Decrypt walks the encrypt schedule backwards: round 1 uses the
    // unrotated halves (total left shift of 28), then rotates right.
    localparam logic [1:0] DEC_SHIFT [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    localparam logic [1:0] ENC_SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [63:0] init_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++)
            y[6'(63 - i)] = x[6'(64 - IP_T[i])];
        return y;
    endfunction

    function automatic logic [63:0] final_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++)
            y[6'(63 - i)] = x[6'(64 - FP_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] expand(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++)
            y[6'(47 - i)] = x[5'(32 - E_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++)
            y[5'(31 - i)] = x[5'(32 - P_T[i])];
        return y;
    endfunction

    // Parity bits (8,16,...,64) are simply never selected.
    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++)
            y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++)
            y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
        return y;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x,
                                          input logic [1:0]  n,
                                          input logic        left);
        case (n)
            2'd1:    return left ? {x[26:0], x[27]} : {x[0], x[27:1]};
            2'd2:    return left ? {x[25:0], x[27:26]} : {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_decrypt_core_if.sv
// des_decrypt_core_if: block-in / block-out valid-ready bundle plus busy.
// master = producer/consumer side, slave = core. DES_ENCRYPT_EN adds mode.
interface des_decrypt_core_if;
    import des_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] cipher_in;
    logic [BLOCK_W-1:0] key_in;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] plaintext_out;
    logic               busy;

`ifdef DES_ENCRYPT_EN
    logic               mode;

    modport master (
        output in_valid, cipher_in, key_in, mode, out_ready,
        input  in_ready, out_valid, plaintext_out, busy
    );
    modport slave (
        input  in_valid, cipher_in, key_in, mode, out_ready,
        output in_ready, out_valid, plaintext_out, busy
    );
`else
    modport master (
        output in_valid, cipher_in, key_in, out_ready,
        input  in_ready, out_valid, plaintext_out, busy
    );
    modport slave (
        input  in_valid, cipher_in, key_in, out_ready,
        output in_ready, out_valid, plaintext_out, busy
    );
`endif

endinterface

// File: rtl/des_f_function.sv
// des_f_function: combinational DES round function f = P(S(E(r) ^ k)).
// Ports: r (32-bit right half), k (48-bit subkey), f (32-bit result).
module des_f_function
    import des_pkg::*;
(
    input  logic [HALF_W-1:0]   r,
    input  logic [SUBKEY_W-1:0] k,
    output logic [HALF_W-1:0]   f
);

    // Entry index is {row, col} = {b1, b6, b2..b5} of each 6-bit group.
    localparam logic [3:0] SBOX [8][64] = '{
        '{4'd14,4'd4,4'd13,4'd1,4'd2,4'd15,4'd11,4'd8,4'd3,4'd10,4'd6,4'd12,4'd5,4'd9,4'd0,4'd7,
          4'd0,4'd15,4'd7,4'd4,4'd14,4'd2,4'd13,4'd1,4'd10,4'd6,4'd12,4'd11,4'd9,4'd5,4'd3,4'd8,
          4'd4,4'd1,4'd14,4'd8,4'd13,4'd6,4'd2,4'd11,4'd15,4'd12,4'd9,4'd7,4'd3,4'd10,4'd5,4'd0,
          4'd15,4'd12,4'd8,4'd2,4'd4,4'd9,4'd1,4'd7,4'd5,4'd11,4'd3,4'd14,4'd10,4'd0,4'd6,4'd13},
        '{4'd15,4'd1,4'd8,4'd14,4'd6,4'd11,4'd3,4'd4,4'd9,4'd7,4'd2,4'd13,4'd12,4'd0,4'd5,4'd10,
          4'd3,4'd13,4'd4,4'd7,4'd15,4'd2,4'd8,4'd14,4'd12,4'd0,4'd1,4'd10,4'd6,4'd9,4'd11,4'd5,
          4'd0,4'd14,4'd7,4'd11,4'd10,4'd4,4'd13,4'd1,4'd5,4'd8,4'd12,4'd6,4'd9,4'd3,4'd2,4'd15,
          4'd13,4'd8,4'd10,4'd1,4'd3,4'd15,4'd4,4'd2,4'd11,4'd6,4'd7,4'd12,4'd0,4'd5,4'd14,4'd9},
        '{4'd10,4'd0,4'd9,4'd14,4'd6,4'd3,4'd15,4'd5,4'd1,4'd13,4'd12,4'd7,4'd11,4'd4,4'd2,4'd8,
          4'd13,4'd7,4'd0,4'd9,4'd3,4'd4,4'd6,4'd10,4'd2,4'd8,4'd5,4'd14,4'd12,4'd11,4'd15,4'd1,
          4'd13,4'd6,4'd4,4'd9,4'd8,4'd15,4'd3,4'd0,4'd11,4'd1,4'd2,4'd12,4'd5,4'd10,4'd14,4'd7,
          4'd1,4'd10,4'd13,4'd0,4'd6,4'd9,4'd8,4'd7,4'd4,4'd15,4'd14,4'd3,4'd11,4'd5,4'd2,4'd12},
        '{4'd7,4'd13,4'd14,4'd3,4'd0,4'd6,4'd9,4'd10,4'd1,4'd2,4'd8,4'd5,4'd11,4'd12,4'd4,4'd15,
          4'd13,4'd8,4'd11,4'd5,4'd6,4'd15,4'd0,4'd3,4'd4,4'd7,4'd2,4'd12,4'd1,4'd10,4'd14,4'd9,
          4'd10,4'd6,4'd9,4'd0,4'd12,4'd11,4'd7,4'd13,4'd15,4'd1,4'd3,4'd14,4'd5,4'd2,4'd8,4'd4,
          4'd3,4'd15,4'd0,4'd6,4'd10,4'd1,4'd13,4'd8,4'd9,4'd4,4'd5,4'd11,4'd12,4'd7,4'd2,4'd14},
        '{4'd2,4'd12,4'd4,4'd1,4'd7,4'd10,4'd11,4'd6,4'd8,4'd5,4'd3,4'd15,4'd13,4'd0,4'd14,4'd9,
          4'd14,4'd11,4'd2,4'd12,4'd4,4'd7,4'd13,4'd1,4'd5,4'd0,4'd15,4'd10,4'd3,4'd9,4'd8,4'd6,
          4'd4,4'd2,4'd1,4'd11,4'd10,4'd13,4'd7,4'd8,4'd15,4'd9,4'd12,4'd5,4'd6,4'd3,4'd0,4'd14,
          4'd11,4'd8,4'd12,4'd7,4'd1,4'd14,4'd2,4'd13,4'd6,4'd15,4'd0,4'd9,4'd10,4'd4,4'd5,4'd3},
        '{4'd12,4'd1,4'd10,4'd15,4'd9,4'd2,4'd6,4'd8,4'd0,4'd13,4'd3,4'd4,4'd14,4'd7,4'd5,4'd11,
          4'd10,4'd15,4'd4,4'd2,4'd7,4'd12,4'd9,4'd5,4'd6,4'd1,4'd13,4'd14,4'd0,4'd11,4'd3,4'd8,
          4'd9,4'd14,4'd15,4'd5,4'd2,4'd8,4'd12,4'd3,4'd7,4'd0,4'd4,4'd10,4'd1,4'd13,4'd11,4'd6,
          4'd4,4'd3,4'd2,4'd12,4'd9,4'd5,4'd15,4'd10,4'd11,4'd14,4'd1,4'd7,4'd6,4'd0,4'd8,4'd13},
        '{4'd4,4'd11,4'd2,4'd14,4'd15,4'd0,4'd8,4'd13,4'd3,4'd12,4'd9,4'd7,4'd5,4'd10,4'd6,4'd1,
          4'd13,4'd0,4'd11,4'd7,4'd4,4'd9,4'd1,4'd10,4'd14,4'd3,4'd5,4'd12,4'd2,4'd15,4'd8,4'd6,
          4'd1,4'd4,4'd11,4'd13,4'd12,4'd3,4'd7,4'd14,4'd10,4'd15,4'd6,4'd8,4'd0,4'd5,4'd9,4'd2,
          4'd6,4'd11,4'd13,4'd8,4'd1,4'd4,4'd10,4'd7,4'd9,4'd5,4'd0,4'd15,4'd14,4'd2,4'd3,4'd12},
        '{4'd13,4'd2,4'd8,4'd4,4'd6,4'd15,4'd11,4'd1,4'd10,4'd9,4'd3,4'd14,4'd5,4'd0,4'd12,4'd7,
          4'd1,4'd15,4'd13,4'd8,4'd10,4'd3,4'd7,4'd4,4'd12,4'd5,4'd6,4'd11,4'd0,4'd14,4'd9,4'd2,
          4'd7,4'd11,4'd4,4'd1,4'd9,4'd12,4'd14,4'd2,4'd0,4'd6,4'd10,4'd13,4'd15,4'd3,4'd5,4'd8,
          4'd2,4'd1,4'd14,4'd7,4'd4,4'd10,4'd8,4'd13,4'd15,4'd12,4'd9,4'd0,4'd3,4'd5,4'd6,4'd11}
    };

    logic [SUBKEY_W-1:0] x;
    logic [HALF_W-1:0]   s;
    logic [5:0]          grp;

    always_comb begin
        x   = expand(r) ^ k;
        s   = '0;
        grp = '0;
        for (int i = 0; i < 8; i++) begin
            grp = x[6'(47 - 6 * i) -: 6];
            s[5'(31 - 4 * i) -: 4] = SBOX[3'(i)][{grp[5], grp[0], grp[4:1]}];
        end
        f = perm_p(s);
    end

endmodule

// File: rtl/des_decrypt_core.sv
// des_decrypt_core: iterative DES, one Feistel round per clock, result 17 cycles after accept.
// Ports: clk, rst (async, active high), bus (slave modport of des_decrypt_core_if).
// Build option DES_ENCRYPT_EN: adds bus.mode (1 = encrypt), latched with the block.
module des_decrypt_core
    import des_pkg::*;
(
    input logic               clk,
    input logic               rst,
    des_decrypt_core_if.slave bus
);

    state_t                state_q, state_d;
    logic [HALF_W-1:0]     l_q, r_q;
    logic [KEY_HALF_W-1:0] c_q, d_q;
    logic [KEY_HALF_W-1:0] c_rot, d_rot;
    logic [3:0]            cnt_q;
    logic [BLOCK_W-1:0]    pt_q;
    logic                  out_valid_q;
    logic [SUBKEY_W-1:0]   subkey;
    logic [HALF_W-1:0]     f_out;
    logic [1:0]            shift;
    logic                  enc;
    logic                  in_ready;
    logic                  busy;

`ifdef DES_ENCRYPT_EN
    logic mode_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mode_q <= 1'b0;
        else if (state_q == IDLE && bus.in_valid)
            mode_q <= bus.mode;
    end

    assign enc = mode_q;
`else
    assign enc = 1'b0;
`endif

    // The rotated halves feed this round's subkey and are written back,
    // so the schedule advances without a separate key-update cycle.
    assign shift  = enc ? ENC_SHIFT[cnt_q] : DEC_SHIFT[cnt_q];
    assign c_rot  = rot28(c_q, shift, enc);
    assign d_rot  = rot28(d_q, shift, enc);
    assign subkey = perm_pc2({c_rot, d_rot});

    des_f_function u_f (
        .r (r_q),
        .k (subkey),
        .f (f_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid)
                    state_d = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (cnt_q == 4'd15)
                    state_d = DONE;
            end
            DONE: begin
                if (out_valid_q && bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            pt_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        {l_q, r_q} <= init_perm(bus.cipher_in);
                        {c_q, d_q} <= perm_pc1(bus.key_in);
                        cnt_q      <= '0;
                    end
                end
                ROUND: begin
                    l_q   <= r_q;
                    r_q   <= l_q ^ f_out;
                    c_q   <= c_rot;
                    d_q   <= d_rot;
                    // wraps 15 -> 0 on the same edge that enters DONE
                    cnt_q <= cnt_q + 4'd1;
                end
                DONE: begin
                    // first DONE cycle registers the swapped, FP'd halves
                    if (!out_valid_q) begin
                        pt_q        <= final_perm({r_q, l_q});
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.busy          = busy;
    assign bus.out_valid     = out_valid_q;
    assign bus.plaintext_out = pt_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// tb_des_decrypt_core: known-answer vectors through a scoreboard queue,
// plus handshake-stall and reset-abort sequences.
module tb_des_decrypt_core;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    des_decrypt_core_if bus ();

    des_decrypt_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] key;
        logic [63:0] cipher;
        logic [63:0] plain;
        int          hold;
        bit          noise;
    } vec_t;

    vec_t        vecs [7];
    logic [63:0] exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the core idle; returns one negedge after accept.
    task automatic start_pair(input logic [63:0] c, input logic [63:0] k);
        bus.in_valid  = 1'b1;
        bus.cipher_in = c;
        bus.key_in    = k;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.cipher_in = {$urandom, $urandom};
        bus.key_in    = {$urandom, $urandom};
    endtask

    task automatic wait_out(output int lat, output int busy_n, output bit rdy);
        lat    = 0;
        busy_n = int'(bus.busy);
        rdy    = bus.in_ready;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            busy_n += int'(bus.busy);
            rdy    |= bus.in_ready;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_one(input logic [63:0] c, input logic [63:0] k,
                           input logic [63:0] e, input int hold,
                           input bit noise);
        int          lat, bn;
        bit          rdy, stable;
        logic [63:0] held;
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        start_pair(c, k);
        exp_q.push_back(e);
        if (noise) begin
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
        end
        wait_out(lat, bn, rdy);
        check("latency", 64'(lat), 64'd17);
        check("busy_cycles", 64'(bn), 64'd16);
        check("in_ready_while_busy", 64'(rdy), 64'd0);
        held   = bus.plaintext_out;
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (bus.plaintext_out !== held || bus.out_valid !== 1'b1 ||
                bus.in_ready !== 1'b0)
                stable = 1'b0;
        end
        if (hold > 0)
            check("hold_stable", 64'(stable), 64'd1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        check("sb_depth", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0)
            check("plaintext", held, exp_q.pop_front());
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_after_hs", 64'(bus.out_valid), 64'd0);
        check("in_ready_after_hs", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bn;
        bit rdy, seen;

        vecs[0] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 0, 1'b0};
        vecs[1] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787, 0, 1'b1};
        // same key as vecs[0] with every parity bit inverted
        vecs[2] = '{64'h123556789ABDDEF0, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 2, 1'b0};
        vecs[3] = '{64'h0123456789ABCDEF, 64'h3FA40E8A984D4815, 64'h4E6F772069732074, 0, 1'b1};
        vecs[4] = '{64'h0101010101010101, 64'h8CA64DE9C1B123A7, 64'h0000000000000000, 10, 1'b0};
        vecs[5] = '{64'h0101010101010101, 64'h95F8A5E5DD31D900, 64'h8000000000000000, 0, 1'b0};
        vecs[6] = '{64'h0101010101010101, 64'hDD7F121CA5015619, 64'h4000000000000000, 1, 1'b1};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.cipher_in = '0;
        bus.key_in    = '0;
`ifdef DES_ENCRYPT_EN
        bus.mode      = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_plaintext", bus.plaintext_out, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_one(vecs[i].cipher, vecs[i].key, vecs[i].plain,
                    vecs[i].hold, vecs[i].noise);

        // reset in the middle of the rounds
        start_pair(vecs[0].cipher, vecs[0].key);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen |= bus.out_valid;
        end
        check("abort_no_out", 64'(seen), 64'd0);
        run_one(vecs[0].cipher, vecs[0].key, vecs[0].plain, 0, 1'b0);

        // reset while the result is waiting; accept right after release
        start_pair(vecs[1].cipher, vecs[1].key);
        wait_out(lat, bn, rdy);
        check("done_latency", 64'(lat), 64'd17);
        rst = 1'b1;
        #1;
        check("done_abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("done_abort_plaintext", bus.plaintext_out, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_one(vecs[3].cipher, vecs[3].key, vecs[3].plain, 0, 1'b0);

`ifdef DES_ENCRYPT_EN
        bus.mode = 1'b1;
        run_one(64'h0123456789ABCDEF, 64'h133457799BBCDFF1,
                64'h85E813540F0AB405, 0, 1'b0);
        bus.mode = 1'b0;
`endif

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
